// File: rtl/port_rst_sched.sv
// ---------------------------------------------------------------------------
// port_rst_sched
//   Per-port soft-reset scheduler. Reset requests from up to NUM_PORTS
//   requesters are captured in a pending vector and serviced one at a time,
//   round-robin. Each serviced port is held in reset for HOLD_CYCLES cycles,
//   then left quiet for SETTLE_CYCLES cycles before the next port is granted.
//   This gives FIFOs on both clock sides time to finish resetting.
//
// Ports
//   sys_clk    in   system clock
//   rst_sys    in   synchronous active-high reset
//   hold_all   in   level; holds every port in reset and freezes the scheduler
//   req        in   [NUM_PORTS] per-port reset request (pulse)
//   rstn_port  out  [NUM_PORTS] registered active-low per-port reset
//   busy       out  high whenever the scheduler is not IDLE
//   cur_port   out  port currently being serviced
//   done       out  one-cycle pulse at the end of a port's sequence
//   done_port  out  port index qualified by done
// ---------------------------------------------------------------------------
module port_rst_sched #(
    parameter int NUM_PORTS     = 4,
    parameter int HOLD_CYCLES   = 128,
    parameter int SETTLE_CYCLES = 64,
    parameter int INIT_ALL      = 1,
    localparam int PW           = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 sys_clk,
    input  logic                 rst_sys,
    input  logic                 hold_all,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] rstn_port,
    output logic                 busy,
    output logic [PW-1:0]        cur_port,
    output logic                 done,
    output logic [PW-1:0]        done_port
);

    localparam int MAXC = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [4:0] {
        ST_INIT   = 5'b00001,
        ST_IDLE   = 5'b00010,
        ST_ASSERT = 5'b00100,
        ST_SETTLE = 5'b01000,
        ST_DONE   = 5'b10000
    } state_t;

    state_t               state_r;
    logic [CW-1:0]        cnt_r;
    logic [NUM_PORTS-1:0] pending_r;
    logic [PW-1:0]        rr_ptr_r;

    logic                 grant_vld_s;
    logic [PW-1:0]        grant_idx_s;
    logic [NUM_PORTS-1:0] grant_mask_s;
    logic [NUM_PORTS-1:0] pending_clr_s;
    logic [NUM_PORTS-1:0] pending_nxt_s;

    // Round-robin pick: first pending bit at rr_ptr+1, rr_ptr+2, ... with wrap.
    // Scanning from the farthest offset down lets the nearest hit win.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = {PW{1'b0}};
        for (int k = NUM_PORTS; k >= 1; k--) begin
            if (pending_r[PW'((int'(rr_ptr_r) + k) % NUM_PORTS)]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = PW'((int'(rr_ptr_r) + k) % NUM_PORTS);
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // One-hot grant mask and next pending vector. A request arriving on the
    // grant cycle for the same port wins over the clear, so it is re-serviced.
    always_comb begin
        grant_mask_s = {NUM_PORTS{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            grant_mask_s[i] = grant_vld_s && (grant_idx_s == PW'(i));
        end
        if (!hold_all && (state_r == ST_IDLE)) begin
            pending_clr_s = grant_mask_s;
        end else begin
            pending_clr_s = {NUM_PORTS{1'b0}};
        end
        pending_nxt_s = (pending_r & ~pending_clr_s) | req;
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge sys_clk) begin
        if (rst_sys) begin
            state_r   <= (INIT_ALL != 0) ? ST_INIT : ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            pending_r <= {NUM_PORTS{1'b0}};
            rr_ptr_r  <= PW'(NUM_PORTS - 1);
            rstn_port <= {NUM_PORTS{1'b0}};
            busy      <= 1'b1;
            done      <= 1'b0;
            cur_port  <= {PW{1'b0}};
            done_port <= {PW{1'b0}};
        end else if (hold_all) begin
            // Abort whatever is in flight; INIT restarts once hold_all falls.
            state_r   <= ST_INIT;
            cnt_r     <= {CW{1'b0}};
            pending_r <= pending_nxt_s;
            rstn_port <= {NUM_PORTS{1'b0}};
            busy      <= 1'b1;
            done      <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            done      <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_r   <= ST_IDLE;
                        cnt_r     <= {CW{1'b0}};
                        rstn_port <= {NUM_PORTS{1'b1}};
                        busy      <= 1'b0;
                    end else begin
                        cnt_r     <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        rstn_port <= {NUM_PORTS{1'b0}};
                        busy      <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (grant_vld_s) begin
                        state_r   <= ST_ASSERT;
                        cnt_r     <= {CW{1'b0}};
                        cur_port  <= grant_idx_s;
                        rr_ptr_r  <= grant_idx_s;
                        rstn_port <= ~grant_mask_s;
                        busy      <= 1'b1;
                    end else begin
                        rstn_port <= {NUM_PORTS{1'b1}};
                        busy      <= 1'b0;
                    end
                end
                ST_ASSERT: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_r   <= ST_SETTLE;
                        cnt_r     <= {CW{1'b0}};
                        rstn_port <= {NUM_PORTS{1'b1}};
                    end else begin
                        cnt_r     <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        state_r   <= ST_DONE;
                        cnt_r     <= {CW{1'b0}};
                        done      <= 1'b1;
                        done_port <= cur_port;
                    end else begin
                        cnt_r     <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CW{1'b0}};
                    busy    <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: recover through a full INIT.
                    state_r   <= ST_INIT;
                    cnt_r     <= {CW{1'b0}};
                    rstn_port <= {NUM_PORTS{1'b0}};
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_port_rst_sched.sv
// ---------------------------------------------------------------------------
// tb_port_rst_sched
//   Directed bench for port_rst_sched (4 ports, HOLD=128, SETTLE=64).
//   Expected values are hand-computed cycle offsets kept in a small table of
//   vec_t records; a negedge monitor counts done pulses and per-port starts.
// ---------------------------------------------------------------------------
module tb_port_rst_sched;

    logic       sys_clk;
    logic       rst_sys;
    logic       hold_all;
    logic [3:0] req;
    logic [3:0] rstn_port;
    logic       busy;
    logic [1:0] cur_port;
    logic       done;
    logic [1:0] done_port;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int done_cnt = 0;
    int starts [4];
    logic [3:0] prev_rstn;

    typedef struct {
        int         off;
        logic [3:0] rstn;
        logic       bsy;
        logic       dn;
        logic [1:0] dp;
        logic       cur_chk;
        logic [1:0] cur;
    } vec_t;

    vec_t tq [$];

    port_rst_sched #(
        .NUM_PORTS    (4),
        .HOLD_CYCLES  (128),
        .SETTLE_CYCLES(64),
        .INIT_ALL     (1)
    ) dut (
        .sys_clk  (sys_clk),
        .rst_sys  (rst_sys),
        .hold_all (hold_all),
        .req      (req),
        .rstn_port(rstn_port),
        .busy     (busy),
        .cur_port (cur_port),
        .done     (done),
        .done_port(done_port)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Cycle index: at the negedge of cycle k, cyc == k.
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 4; i++) starts[i] = 0;
        prev_rstn = 4'b0000;
    end

    // Count done pulses and single-port reset starts (1111 -> one bit low).
    always @(negedge sys_clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (prev_rstn == 4'b1111 && $countones(rstn_port) == 3) begin
            for (int i = 0; i < 4; i++) begin
                if (rstn_port[i] == 1'b0) starts[i] <= starts[i] + 1;
            end
        end
        prev_rstn <= rstn_port;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge sys_clk);
    endtask

    task automatic add(input int off, input logic [3:0] rn, input logic b, input logic d,
                       input logic [1:0] dp, input logic cc, input logic [1:0] cur);
        vec_t v;
        v.off = off; v.rstn = rn; v.bsy = b; v.dn = d; v.dp = dp; v.cur_chk = cc; v.cur = cur;
        tq.push_back(v);
    endtask

    task automatic apply_tbl(input int base, input string tag);
        for (int i = 0; i < tq.size(); i++) begin
            goto(base + tq[i].off);
            chk($sformatf("%s+%0d rstn", tag, tq[i].off), 32'(rstn_port), 32'(tq[i].rstn));
            chk($sformatf("%s+%0d busy", tag, tq[i].off), 32'(busy), 32'(tq[i].bsy));
            chk($sformatf("%s+%0d done", tag, tq[i].off), 32'(done), 32'(tq[i].dn));
            if (tq[i].dn) chk($sformatf("%s+%0d done_port", tag, tq[i].off), 32'(done_port), 32'(tq[i].dp));
            if (tq[i].cur_chk) chk($sformatf("%s+%0d cur_port", tag, tq[i].off), 32'(cur_port), 32'(tq[i].cur));
        end
        tq.delete();
    endtask

    task automatic pulse_req(input logic [3:0] r);
        req = r;
        @(negedge sys_clk);
        req = 4'b0000;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rstn"}, 32'(rstn_port), 32'(4'b0000));
        chk({tag, " busy"}, 32'(busy), 32'(1'b1));
        chk({tag, " done"}, 32'(done), 32'(1'b0));
        chk({tag, " cur_port"}, 32'(cur_port), 32'(2'd0));
        chk({tag, " done_port"}, 32'(done_port), 32'(2'd0));
    endtask

    int k0, t, h, s, dc, sv;

    initial begin
        rst_sys  = 1'b1;
        hold_all = 1'b0;
        req      = 4'b0000;
        repeat (3) @(negedge sys_clk);

        // ---- Reset values, then INIT: 128 low cycles, no done ----
        chk_reset_vals("rst");
        rst_sys = 1'b0;
        k0 = cyc;
        add(0,   4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        add(64,  4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        add(127, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        add(128, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        add(129, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        apply_tbl(k0, "init");
        chk("init no done", 32'(done_cnt), 32'd0);

        // ---- Single request for port 2 ----
        t = k0 + 140;
        goto(t);
        pulse_req(4'b0100);
        add(1,   4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        add(2,   4'b1011, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2);
        add(129, 4'b1011, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2);
        add(130, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        add(193, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        add(194, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0);
        add(195, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        apply_tbl(t, "single");

        // ---- rst_sys mid-SETTLE of port 3, port 1 pending ----
        t = t + 200;
        goto(t);
        pulse_req(4'b1000);
        goto(t + 50);
        pulse_req(4'b0010);
        s = t + 160;
        goto(s);
        chk("settle rstn", 32'(rstn_port), 32'(4'b1111));
        chk("settle cur_port", 32'(cur_port), 32'(2'd3));
        rst_sys = 1'b1;
        goto(s + 1);
        chk_reset_vals("midrst");
        rst_sys = 1'b0;
        k0 = cyc;
        sv = starts[1];
        add(127, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        add(128, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        add(400, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        apply_tbl(k0, "postrst");
        chk("pending lost port1", 32'(starts[1] - sv), 32'd0);

        // ---- Simultaneous requests 1011 with rr_ptr=3: order 0,1,3 ----
        t = cyc;
        sv = starts[2];
        pulse_req(4'b1011);
        add(2,   4'b1110, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0);
        add(194, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
        add(196, 4'b1101, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1);
        add(388, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0);
        add(390, 4'b0111, 1'b1, 1'b0, 2'd0, 1'b1, 2'd3);
        add(582, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b0, 2'd0);
        add(583, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        apply_tbl(t, "simul");
        chk("simul port2 untouched", 32'(starts[2] - sv), 32'd0);

        // ---- Re-request of port 1 during its own ASSERT ----
        t = cyc + 10;
        goto(t);
        pulse_req(4'b0010);
        goto(t + 2);
        chk("rereq first rstn", 32'(rstn_port), 32'(4'b1101));
        goto(t + 50);
        pulse_req(4'b0010);
        add(194, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0);
        add(195, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        add(196, 4'b1101, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1);
        add(388, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0);
        add(389, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        apply_tbl(t, "rereq");

        // ---- hold_all for 10 cycles mid-ASSERT of port 3, port 0 pending ----
        t = cyc + 10;
        goto(t);
        pulse_req(4'b1000);
        goto(t + 20);
        pulse_req(4'b0001);
        goto(t + 30);
        chk("hold pre rstn", 32'(rstn_port), 32'(4'b0111));
        sv = starts[3];
        dc = done_cnt;
        h = t + 60;
        goto(h);
        hold_all = 1'b1;
        goto(h + 1);
        chk("hold rstn", 32'(rstn_port), 32'(4'b0000));
        chk("hold busy", 32'(busy), 32'(1'b1));
        goto(h + 10);
        hold_all = 1'b0;
        add(10,  4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        add(137, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        add(138, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        add(139, 4'b1110, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0);
        add(330, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        add(331, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
        add(332, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        apply_tbl(h, "hold");
        goto(h + 340);
        chk("hold done count", 32'(done_cnt - dc), 32'd1);
        goto(h + 600);
        chk("hold port3 not redone", 32'(starts[3] - sv), 32'd0);
        chk("hold final busy", 32'(busy), 32'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/port_rst_sched.md
Name: port_rst_sched

Overview:
- Per-port soft-reset scheduler for the switch. Accepts reset requests from up to NUM_PORTS requesters (link-loss detectors, management writes) and serialises them round-robin.
- Drives one active-low reset per MAC/PHY port. Each reset is held for HOLD_CYCLES, followed by a SETTLE_CYCLES quiet window, so FIFOs on both clock sides finish resetting before the next port is touched.
- Sits in the sys_clk domain, downstream of the global reset controller.

Parameters:
- NUM_PORTS, 4, number of port reset outputs and request inputs (1..16).
- HOLD_CYCLES, 128, cycles rstn_port[i] is held low per reset (>=1).
- SETTLE_CYCLES, 64, cycles after release before the next grant (>=1).
- INIT_ALL, 1, when 1: after rst_sys deasserts, all ports are held low HOLD_CYCLES, then released together.

Ports:
- sys_clk  in  1  system clock.
- rst_sys  in  1  synchronous active-high reset.
- hold_all  in  1  level; while high, all ports are held in reset and the scheduler is frozen.
- req  in  NUM_PORTS  per-port reset request, single-cycle pulse or level.
- rstn_port  out  NUM_PORTS  registered active-low per-port reset.
- busy  out  1  high in any state other than IDLE.
- cur_port  out  clog2(NUM_PORTS) (min 1)  index of the port being serviced; valid while busy and not INIT.
- done  out  1  one-cycle pulse when a port's sequence completes.
- done_port  out  clog2(NUM_PORTS) (min 1)  index qualified by done.

Behaviour:
- Reset is synchronous and active-high: rst_sys sampled high at a sys_clk edge resets all state.
- Values during rst_sys:
  - rstn_port = all 0.
  - pending = 0, rr_ptr = NUM_PORTS-1, cnt = 0.
  - busy = 1, done = 0, cur_port = 0, done_port = 0.
  - State = INIT if INIT_ALL=1, else IDLE. With INIT_ALL=0, rstn_port = all 1 from the first cycle after reset.
- pending[i]:
  - Set on any cycle req[i]=1.
  - Cleared on the cycle port i is granted.
  - A req[i] arriving while port i is being serviced re-sets pending[i]. Port i is reset again on a later grant; the request is not merged.
- A held level req[i] therefore re-triggers continuously. Requesters must pulse.
- States (one-hot: INIT, IDLE, ASSERT, SETTLE, DONE):
  - INIT: all rstn_port low. cnt counts 0..HOLD_CYCLES-1. On the last count, go to IDLE and drive rstn_port = all 1 from the next cycle. Requests received during INIT are kept pending.
  - IDLE: if pending != 0, grant the first set bit searching from rr_ptr+1 with wrap-around. Latch cur_port, set rr_ptr = grant, clear that pending bit, go to ASSERT. Otherwise stay.
  - ASSERT: rstn_port[cur_port] = 0 for exactly HOLD_CYCLES cycles, starting the cycle after the grant edge. All other ports stay 1. Then go to SETTLE.
  - SETTLE: rstn_port[cur_port] = 1. Wait SETTLE_CYCLES cycles, then go to DONE.
  - DONE: done = 1 and done_port = cur_port for one cycle, then go to IDLE.
- Latency and throughput:
  - req pulse at cycle t with the scheduler idle: pending visible at t+1, grant at the t+1 edge, rstn_port low on cycles t+2 .. t+1+HOLD_CYCLES.
  - done is high on cycle t+2+HOLD_CYCLES+SETTLE_CYCLES.
  - Minimum spacing between successive port resets: HOLD_CYCLES+SETTLE_CYCLES+2 cycles.
- Simultaneous requests: all are captured. Service order is round-robin from rr_ptr+1, so no port is starved. Each port waits at most NUM_PORTS-1 sequences.
- hold_all=1 (any state):
  - rstn_port = all 0 from the next cycle.
  - In-flight sequence is aborted and done is not pulsed.
  - pending is retained; new req are still captured.
  - State goes to INIT with cnt = 0.
- hold_all falling: the INIT sequence runs regardless of INIT_ALL, then pending requests are serviced.
- rst_sys mid-sequence: immediate return to reset values. Pending requests are lost.
- Counter: cnt is clog2(max(HOLD_CYCLES,SETTLE_CYCLES)) bits. It is cleared on every state change and never wraps within a state.
- All outputs are registered. No combinational path from req or hold_all to any output.

Test Plan:
- Init, INIT_ALL=1, HOLD=128: release rst_sys -> rstn_port=4'b0000 for exactly 128 cycles, then 4'b1111; busy falls the same cycle; no done pulse.
- Single request: 1-cycle req=4'b0100 in IDLE at cycle t -> rstn_port[2] low on t+2..t+129, other bits stay 1; done=1 with done_port=2 at t+194; busy low at t+195.
- Simultaneous: req=4'b1011 for one cycle with rr_ptr=3 -> ports serviced in order 0, 1, 3; three done pulses spaced 194 cycles apart; port 2 is never reset.
- Re-request during service: req[1] pulsed again during port 1's ASSERT -> after done_port=1, port 1 is granted again on the next IDLE cycle.
- hold_all=1 for 10 cycles mid-ASSERT of port 3, with pending=4'b0001 -> rstn_port=0000 next cycle; no done for port 3; after the fall, 128-cycle INIT; port 0 serviced next; port 3 not re-serviced unless re-requested.
- rst_sys mid-SETTLE, with a pending request outstanding -> next cycle all outputs at reset values; pending is cleared, so that port is not reset later without a new req.
